sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 16 +
 rtl/sdram_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM client command encodings and burst length, common to the
// arbiter, its clients and the controller.
package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam int unsigned SDRAM_READ_BURST_LENGTH = 4;

    // Encoding 2'd3 is unused and deliberately treated as idle.
    function automatic logic cmd_active(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM arbiter: the display reader has strict priority over the
// compute client, which can be asked to yield mid-grant.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned READ_BURST_LENGTH = SDRAM_READ_BURST_LENGTH
) (
    input  logic        i_Clk,
    input  logic        i_Reset,

    input  logic [1:0]  i_Disp_Command,
    input  logic [21:0] i_Disp_Address,
    output logic        o_Disp_Read_Valid,
    output logic        o_Disp_Write_Done,

    input  logic [1:0]  i_CPU_Command,
    input  logic [21:0] i_CPU_Address,
    input  logic [31:0] i_CPU_Write_Data,
    input  logic        i_CPU_SDRAM_Yield,
    output logic        o_CPU_SDRAM_Requested,
    output logic        o_CPU_Read_Valid,
    output logic        o_CPU_Write_Done,

    output logic [31:0] o_Read_Data,

    output logic [1:0]  o_Ctrl_Command,
    output logic [21:0] o_Ctrl_Address,
    output logic [31:0] o_Ctrl_Write_Data,
    input  logic        i_Ctrl_Read_Valid,
    input  logic        i_Ctrl_Write_Done,
    input  logic [31:0] i_Ctrl_Read_Data,

    output logic        o_Burst_Error
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_GRANT_DISP = 2'd1;
    localparam logic [1:0] ST_GRANT_CPU  = 2'd2;

    localparam logic [7:0] BURST_LEN = 8'(READ_BURST_LENGTH);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] beat_count;
    logic [7:0] beat_next;
    logic       burst_error;

    logic       disp_active;
    logic       cpu_active;
    logic       disp_granted;
    logic       cpu_granted;
    logic       read_routed;
    logic       write_routed;
    logic [1:0] strobe_count;
    logic       release_grant;

    always_comb begin
        disp_active  = cmd_active(i_Disp_Command);
        cpu_active   = cmd_active(i_CPU_Command);
        // Grants are masked during reset so nothing leaks out mid-burst.
        disp_granted = (state == ST_GRANT_DISP) && !i_Reset;
        cpu_granted  = (state == ST_GRANT_CPU) && !i_Reset;

        o_CPU_SDRAM_Requested = disp_active && (state != ST_GRANT_DISP);

        o_Ctrl_Command = CMD_IDLE;
        o_Ctrl_Address = '0;
        if (disp_granted) begin
            o_Ctrl_Address = i_Disp_Address;
            if (disp_active) begin
                o_Ctrl_Command = CMD_READ;
            end
        end else if (cpu_granted) begin
            o_Ctrl_Address = i_CPU_Address;
            if (cpu_active) begin
                o_Ctrl_Command = i_CPU_Command;
            end
        end

        o_Ctrl_Write_Data = i_CPU_Write_Data;
        o_Read_Data       = i_Ctrl_Read_Data;

        o_Disp_Read_Valid = disp_granted && i_Ctrl_Read_Valid;
        o_Disp_Write_Done = disp_granted && i_Ctrl_Write_Done;
        o_CPU_Read_Valid  = cpu_granted && i_Ctrl_Read_Valid;
        o_CPU_Write_Done  = cpu_granted && i_Ctrl_Write_Done;

        read_routed  = (disp_granted || cpu_granted) && i_Ctrl_Read_Valid;
        write_routed = (disp_granted || cpu_granted) && i_Ctrl_Write_Done;
        strobe_count = {1'b0, read_routed} + {1'b0, write_routed};
        beat_next    = beat_count + {6'd0, strobe_count};

        release_grant = ((state == ST_GRANT_DISP) && !disp_active) ||
                        ((state == ST_GRANT_CPU) &&
                         (!cpu_active || (o_CPU_SDRAM_Requested && i_CPU_SDRAM_Yield)));

        state_next = state;
        case (state)
            ST_IDLE: begin
                if (disp_active) begin
                    state_next = ST_GRANT_DISP;
                end else if (cpu_active) begin
                    state_next = ST_GRANT_CPU;
                end
            end
            ST_GRANT_DISP,
            ST_GRANT_CPU: begin
                if (release_grant) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        o_Burst_Error = burst_error;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            beat_count  <= '0;
            burst_error <= 1'b0;
        end else begin
            state <= state_next;
            // Holding the count at zero in IDLE clears it for the next grant.
            if (state == ST_IDLE) begin
                beat_count <= '0;
            end else begin
                beat_count <= beat_next;
            end
            if (release_grant && (beat_next != 8'd0) && ((beat_next % BURST_LEN) != 8'd0)) begin
                burst_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: strobe scoreboard plus per-cycle checks
// of the controller-side mux, preemption request and burst error flag.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  disp_cmd;
    logic [21:0] disp_addr;
    logic        disp_rv;
    logic        disp_wd;
    logic [1:0]  cpu_cmd;
    logic [21:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_yield;
    logic        cpu_req;
    logic        cpu_rv;
    logic        cpu_wd;
    logic [31:0] rdata;
    logic [1:0]  ctrl_cmd;
    logic [21:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_rv;
    logic        ctrl_wd;
    logic [31:0] ctrl_rdata;
    logic        burst_err;

    sdram_arbiter #(.READ_BURST_LENGTH(4)) dut (
        .i_Clk                 (clk),
        .i_Reset               (rst),
        .i_Disp_Command        (disp_cmd),
        .i_Disp_Address        (disp_addr),
        .o_Disp_Read_Valid     (disp_rv),
        .o_Disp_Write_Done     (disp_wd),
        .i_CPU_Command         (cpu_cmd),
        .i_CPU_Address         (cpu_addr),
        .i_CPU_Write_Data      (cpu_wdata),
        .i_CPU_SDRAM_Yield     (cpu_yield),
        .o_CPU_SDRAM_Requested (cpu_req),
        .o_CPU_Read_Valid      (cpu_rv),
        .o_CPU_Write_Done      (cpu_wd),
        .o_Read_Data           (rdata),
        .o_Ctrl_Command        (ctrl_cmd),
        .o_Ctrl_Address        (ctrl_addr),
        .o_Ctrl_Write_Data     (ctrl_wdata),
        .i_Ctrl_Read_Valid     (ctrl_rv),
        .i_Ctrl_Write_Done     (ctrl_wd),
        .i_Ctrl_Read_Data      (ctrl_rdata),
        .o_Burst_Error         (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind bits: {disp_read_valid, disp_write_done, cpu_read_valid, cpu_write_done}
    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
    } strobe_t;

    strobe_t exp_q[$];
    int      checks = 0;
    int      failures = 0;

    localparam logic [3:0] K_DRV = 4'b1000;
    localparam logic [3:0] K_CRV = 4'b0010;
    localparam logic [3:0] K_CWD = 4'b0001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] seen;
        strobe_t    e;
        seen = {disp_rv, disp_wd, cpu_rv, cpu_wd};
        if (seen != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%b expected=none", seen);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(seen), 32'(e.kind));
                if (e.kind[3] || e.kind[1]) begin
                    check("strobe_read_data", rdata, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [1:0] cmd, input logic [21:0] addr);
        disp_cmd  = cmd;
        disp_addr = addr;
    endtask

    task automatic set_cpu(input logic [1:0] cmd, input logic [21:0] addr,
                           input logic [31:0] wdata, input logic yield);
        cpu_cmd   = cmd;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_yield = yield;
    endtask

    task automatic set_ctrl(input logic rv, input logic wd, input logic [31:0] data);
        ctrl_rv    = rv;
        ctrl_wd    = wd;
        ctrl_rdata = data;
    endtask

    task automatic expect_strobe(input logic [3:0] kind, input logic [31:0] data);
        strobe_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sample(input string tag, input logic [1:0] exp_cmd, input logic [21:0] exp_addr,
                          input logic exp_req, input logic exp_err);
        @(negedge clk);
        check($sformatf("%s.cmd", tag), 32'(ctrl_cmd), 32'(exp_cmd));
        check($sformatf("%s.addr", tag), 32'(ctrl_addr), 32'(exp_addr));
        check($sformatf("%s.requested", tag), 32'(cpu_req), 32'(exp_req));
        check($sformatf("%s.burst_error", tag), 32'(burst_err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        set_disp(CMD_IDLE, 22'h0);
        set_cpu(CMD_IDLE, 22'h0, 32'h0, 1'b0);
        set_ctrl(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        sample("reset", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // CPU read burst alone
        set_cpu(CMD_READ, 22'h000123, 32'h0, 1'b0);
        sample("t1_turn", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();
        sample("t1_grant", CMD_READ, 22'h000123, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_ctrl(1'b1, 1'b0, 32'hA000_0000 + 32'(i));
            expect_strobe(K_CRV, 32'hA000_0000 + 32'(i));
            sample("t1_beat", CMD_READ, 22'h000123, 1'b0, 1'b0);
            tick();
        end
        set_ctrl(1'b0, 1'b0, 32'h0);
        set_cpu(CMD_IDLE, 22'h000123, 32'h0, 1'b0);
        sample("t1_rel", CMD_IDLE, 22'h000123, 1'b0, 1'b0);
        tick();
        sample("t1_idle", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();

        // Simultaneous requests: display wins, display write forwarded as read
        set_disp(CMD_READ, 22'h155555);
        set_cpu(CMD_WRITE, 22'h000456, 32'hDEAD_BEEF, 1'b0);
        sample("t2_turn", CMD_IDLE, 22'h0, 1'b1, 1'b0);
        tick();
        set_disp(CMD_WRITE, 22'h155555);
        sample("t2_fwd", CMD_READ, 22'h155555, 1'b0, 1'b0);
        tick();
        set_disp(CMD_READ, 22'h155555);
        for (int i = 0; i < 4; i++) begin
            set_ctrl(1'b1, 1'b0, 32'hB000_0000 + 32'(i));
            expect_strobe(K_DRV, 32'hB000_0000 + 32'(i));
            sample("t2_beat", CMD_READ, 22'h155555, 1'b0, 1'b0);
            tick();
        end
        set_ctrl(1'b0, 1'b0, 32'h0);
        set_disp(CMD_IDLE, 22'h155555);
        sample("t2_rel", CMD_IDLE, 22'h155555, 1'b0, 1'b0);
        tick();
        sample("t2_turn2", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();
        sample("t2_cpu", CMD_WRITE, 22'h000456, 1'b0, 1'b0);
        check("t2_write_data", ctrl_wdata, 32'hDEAD_BEEF);
        tick();

        // CPU write preempted by display via yield
        for (int i = 0; i < 4; i++) begin
            set_ctrl(1'b0, 1'b1, 32'h0);
            expect_strobe(K_CWD, 32'h0);
            sample("t3_beat", CMD_WRITE, 22'h000456, 1'b0, 1'b0);
            tick();
        end
        set_ctrl(1'b0, 1'b0, 32'h0);
        set_disp(CMD_READ, 22'h0000AA);
        sample("t3_req", CMD_WRITE, 22'h000456, 1'b1, 1'b0);
        tick();
        cpu_yield = 1'b1;
        sample("t3_yield", CMD_WRITE, 22'h000456, 1'b1, 1'b0);
        tick();
        set_cpu(CMD_IDLE, 22'h000456, 32'h0, 1'b0);
        set_ctrl(1'b0, 1'b1, 32'h0);
        sample("t3_turn", CMD_IDLE, 22'h0, 1'b1, 1'b0);
        check("t3_late_write_done", 32'(cpu_wd), 32'd0);
        tick();
        set_ctrl(1'b0, 1'b0, 32'h0);
        sample("t3_disp", CMD_READ, 22'h0000AA, 1'b0, 1'b0);
        tick();
        set_disp(CMD_IDLE, 22'h0000AA);
        sample("t3_rel", CMD_IDLE, 22'h0000AA, 1'b0, 1'b0);
        tick();
        sample("t3_idle", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();

        // Strobes arriving in IDLE are dropped
        set_ctrl(1'b1, 1'b1, 32'h1357_9BDF);
        sample("t4", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        check("t4_strobes", 32'({disp_rv, disp_wd, cpu_rv, cpu_wd}), 32'd0);
        check("t4_read_data", rdata, 32'h1357_9BDF);
        tick();
        set_ctrl(1'b0, 1'b0, 32'h0);

        // Short burst: 3 beats, the last one in the release cycle
        set_cpu(CMD_READ, 22'h3FFFFF, 32'h0, 1'b0);
        sample("t5_turn", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();
        sample("t5_grant", CMD_READ, 22'h3FFFFF, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_ctrl(1'b1, 1'b0, 32'hC000_0000 + 32'(i));
            expect_strobe(K_CRV, 32'hC000_0000 + 32'(i));
            sample("t5_beat", CMD_READ, 22'h3FFFFF, 1'b0, 1'b0);
            tick();
        end
        set_cpu(CMD_IDLE, 22'h3FFFFF, 32'h0, 1'b0);
        set_ctrl(1'b1, 1'b0, 32'hC000_0002);
        expect_strobe(K_CRV, 32'hC000_0002);
        sample("t5_rel", CMD_IDLE, 22'h3FFFFF, 1'b0, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 32'h0);
        sample("t5_err", CMD_IDLE, 22'h0, 1'b0, 1'b1);
        tick();
        sample("t5_hold", CMD_IDLE, 22'h0, 1'b0, 1'b1);
        tick();

        // Reset in the middle of a display grant
        set_disp(CMD_READ, 22'h2000F0);
        sample("t6_turn", CMD_IDLE, 22'h0, 1'b1, 1'b1);
        tick();
        sample("t6_grant", CMD_READ, 22'h2000F0, 1'b0, 1'b1);
        tick();
        set_ctrl(1'b1, 1'b0, 32'hD000_0000);
        expect_strobe(K_DRV, 32'hD000_0000);
        sample("t6_beat", CMD_READ, 22'h2000F0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        set_ctrl(1'b1, 1'b0, 32'hD000_0001);
        sample("t6_in_rst", CMD_IDLE, 22'h0, 1'b0, 1'b1);
        check("t6_rst_strobe", 32'(disp_rv), 32'd0);
        tick();
        rst = 1'b0;
        set_ctrl(1'b0, 1'b0, 32'h0);
        sample("t6_after", CMD_IDLE, 22'h0, 1'b1, 1'b0);
        tick();
        sample("t6_regrant", CMD_READ, 22'h2000F0, 1'b0, 1'b0);
        tick();
        set_disp(CMD_IDLE, 22'h2000F0);
        sample("t6_rel", CMD_IDLE, 22'h2000F0, 1'b0, 1'b0);
        tick();
        sample("t6_end", CMD_IDLE, 22'h0, 1'b0, 1'b0);
        tick();

        check("missing_strobes", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
